// File: rtl/temporizador_pkg.sv
// Shared types and constants for the time-entry unit: FSM states, digit indices,
// BCD limits, the default preset and wrap-around digit helpers.
package temporizador_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EDIT_SEC,
        ST_EDIT_DSEC,
        ST_EDIT_MIN,
        ST_COMMIT
    } estado_t;

    localparam logic [1:0] DIG_SEG  = 2'd0;
    localparam logic [1:0] DIG_DSEG = 2'd1;
    localparam logic [1:0] DIG_MIN  = 2'd2;
    localparam logic [1:0] DIG_NONE = 2'd3;

    localparam logic [3:0] BCD_MAX_UNI = 4'd9;
    localparam logic [3:0] BCD_MAX_DEC = 4'd5;

    localparam logic [11:0] DEFAULT_PRESET = 12'h100;

    // Wrap inside 0..max with no carry out of the digit.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [3:0] bcd_dec(input logic [3:0] d, input logic [3:0] max);
        return (d == 4'd0 || d > max) ? max : d - 4'd1;
    endfunction

endpackage

// File: rtl/programador_tiempo_antirrebote.sv
// Button conditioner: 2-FF synchronizer, tick-based debounce, press pulse and
// optional auto-repeat while the debounced level stays high.
module antirrebote #(
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned HOLD_MS     = 500,
    parameter int unsigned REPEAT_MS   = 150,
    parameter bit          REPEAT_EN   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_1k,
    input  logic btn,
    output logic evento
);

    localparam int unsigned DW = $clog2(DEBOUNCE_MS + 1);
    localparam int unsigned HW = $clog2(HOLD_MS + 1);

    logic          sync1;
    logic          sync2;
    logic          nivel;
    logic [DW-1:0] deb_cnt;
    logic [HW-1:0] hold_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            nivel    <= 1'b0;
            deb_cnt  <= '0;
            hold_cnt <= '0;
            evento   <= 1'b0;
        end else begin
            sync1  <= btn;
            sync2  <= sync1;
            evento <= 1'b0;

            if (sync2 == nivel) begin
                deb_cnt <= '0;
            end else if (tick_1k) begin
                if (deb_cnt == DW'(DEBOUNCE_MS - 1)) begin
                    deb_cnt <= '0;
                    nivel   <= sync2;
                    if (sync2)
                        evento <= 1'b1;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end

            // After the first repeat the counter is rewound so later repeats land every REPEAT_MS.
            if (REPEAT_EN && nivel) begin
                if (tick_1k) begin
                    if (hold_cnt == HW'(HOLD_MS - 1)) begin
                        hold_cnt <= HW'(HOLD_MS - REPEAT_MS);
                        evento   <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/programador_tiempo.sv
// Time-entry unit: edits a 3-digit BCD preset from four buttons and strobes it
// to the countdown timer on a confirmed non-zero commit.
module programador_tiempo
    import temporizador_pkg::*;
#(
    parameter int unsigned  DEBOUNCE_MS  = 20,
    parameter int unsigned  HOLD_MS      = 500,
    parameter int unsigned  REPEAT_MS    = 150,
    parameter logic [11:0]  DEFAULT_TIME = DEFAULT_PRESET
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1k,
    input  logic        btn_sel,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic        btn_ok,
    output logic [11:0] tiempo_establecido,
    output logic [1:0]  digito_activo,
    output logic        editando,
    output logic        cargar,
    output logic        error_cero
);

    logic ev_sel, ev_inc, ev_dec, ev_ok;
    logic paso;
    estado_t estado;

    antirrebote #(.DEBOUNCE_MS(DEBOUNCE_MS), .HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS), .REPEAT_EN(1'b0))
        u_sel (.clk(clk), .reset(reset), .tick_1k(tick_1k), .btn(btn_sel), .evento(ev_sel));
    antirrebote #(.DEBOUNCE_MS(DEBOUNCE_MS), .HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS), .REPEAT_EN(1'b1))
        u_inc (.clk(clk), .reset(reset), .tick_1k(tick_1k), .btn(btn_inc), .evento(ev_inc));
    antirrebote #(.DEBOUNCE_MS(DEBOUNCE_MS), .HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS), .REPEAT_EN(1'b1))
        u_dec (.clk(clk), .reset(reset), .tick_1k(tick_1k), .btn(btn_dec), .evento(ev_dec));
    antirrebote #(.DEBOUNCE_MS(DEBOUNCE_MS), .HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS), .REPEAT_EN(1'b0))
        u_ok  (.clk(clk), .reset(reset), .tick_1k(tick_1k), .btn(btn_ok),  .evento(ev_ok));

    // Simultaneous inc and dec cancel each other.
    assign paso = ev_inc ^ ev_dec;

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado             <= ST_IDLE;
            tiempo_establecido <= DEFAULT_TIME;
            digito_activo      <= DIG_NONE;
            editando           <= 1'b0;
            cargar             <= 1'b0;
            error_cero         <= 1'b0;
        end else begin
            cargar     <= 1'b0;
            error_cero <= 1'b0;
            case (estado)
                ST_IDLE: begin
                    if (ev_ok) begin
                        estado        <= ST_EDIT_SEC;
                        digito_activo <= DIG_SEG;
                        editando      <= 1'b1;
                    end
                end
                ST_EDIT_SEC, ST_EDIT_DSEC, ST_EDIT_MIN: begin
                    if (ev_ok) begin
                        estado        <= ST_COMMIT;
                        digito_activo <= DIG_NONE;
                        editando      <= 1'b0;
                    end else if (ev_sel) begin
                        case (estado)
                            ST_EDIT_SEC:  begin estado <= ST_EDIT_DSEC; digito_activo <= DIG_DSEG; end
                            ST_EDIT_DSEC: begin estado <= ST_EDIT_MIN;  digito_activo <= DIG_MIN;  end
                            default:      begin estado <= ST_EDIT_SEC;  digito_activo <= DIG_SEG;  end
                        endcase
                    end else if (paso) begin
                        case (estado)
                            ST_EDIT_SEC:
                                tiempo_establecido[3:0] <= ev_inc ? bcd_inc(tiempo_establecido[3:0], BCD_MAX_UNI)
                                                                  : bcd_dec(tiempo_establecido[3:0], BCD_MAX_UNI);
                            ST_EDIT_DSEC:
                                tiempo_establecido[7:4] <= ev_inc ? bcd_inc(tiempo_establecido[7:4], BCD_MAX_DEC)
                                                                  : bcd_dec(tiempo_establecido[7:4], BCD_MAX_DEC);
                            default:
                                tiempo_establecido[11:8] <= ev_inc ? bcd_inc(tiempo_establecido[11:8], BCD_MAX_UNI)
                                                                   : bcd_dec(tiempo_establecido[11:8], BCD_MAX_UNI);
                        endcase
                    end
                end
                ST_COMMIT: begin
                    if (tiempo_establecido != 12'h000) begin
                        cargar <= 1'b1;
                        estado <= ST_IDLE;
                    end else begin
                        error_cero    <= 1'b1;
                        estado        <= ST_EDIT_SEC;
                        digito_activo <= DIG_SEG;
                        editando      <= 1'b1;
                    end
                end
                default: begin
                    estado        <= ST_IDLE;
                    digito_activo <= DIG_NONE;
                    editando      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_programador_tiempo.sv
// Bench for programador_tiempo: directed and random button sequences checked
// against a digit-level model of the time-entry behaviour.
module tb_programador_tiempo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick_1k = 1'b0;
    logic        btn_sel = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic        btn_ok = 1'b0;
    logic [11:0] tiempo_establecido;
    logic [1:0]  digito_activo;
    logic        editando;
    logic        cargar;
    logic        error_cero;

    int checks = 0;
    int failures = 0;
    int n_carg = 0;
    int n_err = 0;
    int tick_div = 0;

    int m_dig[3];
    bit m_edit;
    int m_idx;
    int e_carg = 0;
    int e_err = 0;

    programador_tiempo #(
        .DEBOUNCE_MS(3),
        .HOLD_MS(8),
        .REPEAT_MS(4),
        .DEFAULT_TIME(12'h100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick_1k(tick_1k),
        .btn_sel(btn_sel),
        .btn_inc(btn_inc),
        .btn_dec(btn_dec),
        .btn_ok(btn_ok),
        .tiempo_establecido(tiempo_establecido),
        .digito_activo(digito_activo),
        .editando(editando),
        .cargar(cargar),
        .error_cero(error_cero)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tick_div == 3) begin
            tick_div <= 0;
            tick_1k  <= 1'b1;
        end else begin
            tick_div <= tick_div + 1;
            tick_1k  <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (cargar === 1'b1)     n_carg++;
        if (error_cero === 1'b1) n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] m_val();
        logic [11:0] v;
        v[3:0]  = 4'(m_dig[0]);
        v[7:4]  = 4'(m_dig[1]);
        v[11:8] = 4'(m_dig[2]);
        return v;
    endfunction

    function automatic void m_reset();
        m_dig[0] = 0;
        m_dig[1] = 0;
        m_dig[2] = 1;
        m_edit = 1'b0;
        m_idx = 3;
    endfunction

    // One user action as seen after debouncing: priority ok > sel > inc/dec.
    function automatic void m_apply(input bit s, input bit i, input bit d, input bit o);
        int md;
        if (o) begin
            if (!m_edit) begin
                m_edit = 1'b1;
                m_idx = 0;
            end else if (m_val() != 12'h000) begin
                e_carg++;
                m_edit = 1'b0;
                m_idx = 3;
            end else begin
                e_err++;
                m_idx = 0;
            end
        end else if (m_edit) begin
            if (s) begin
                m_idx = (m_idx + 1) % 3;
            end else if (i ^ d) begin
                md = (m_idx == 1) ? 6 : 10;
                m_dig[m_idx] = i ? (m_dig[m_idx] + 1) % md : (m_dig[m_idx] + md - 1) % md;
            end
        end
    endfunction

    task automatic wait_ms(input int n);
        repeat (4 * n) @(negedge clk);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/valor"}, tiempo_establecido, m_val());
        chk({tag, "/digito"}, digito_activo, m_edit ? m_idx : 3);
        chk({tag, "/editando"}, editando, m_edit);
        chk({tag, "/cargar"}, n_carg, e_carg);
        chk({tag, "/error_cero"}, n_err, e_err);
    endtask

    task automatic press(input bit s, input bit i, input bit d, input bit o, input string tag);
        btn_sel = s; btn_inc = i; btn_dec = d; btn_ok = o;
        wait_ms(5);
        btn_sel = 0; btn_inc = 0; btn_dec = 0; btn_ok = 0;
        wait_ms(10);
        m_apply(s, i, d, o);
        check_all(tag);
    endtask

    task automatic set_value(input logic [11:0] tgt);
        int guard;
        if (!m_edit) press(0, 0, 0, 1, "set_ok");
        for (int dg = 0; dg < 3; dg++) begin
            guard = 0;
            while (m_idx != dg && guard < 4) begin
                press(1, 0, 0, 0, "set_sel");
                guard++;
            end
            guard = 0;
            while (m_dig[dg] != int'(tgt[dg*4 +: 4]) && guard < 10) begin
                press(0, 1, 0, 0, "set_inc");
                guard++;
            end
        end
    endtask

    initial begin
        int k;
        int r;
        m_reset();

        // reset state
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_valor", tiempo_establecido, 12'h100);
        chk("rst_digito", digito_activo, 2'd3);
        chk("rst_editando", editando, 1'b0);
        chk("rst_cargar", cargar, 1'b0);
        chk("rst_error", error_cero, 1'b0);
        reset = 1'b1;
        wait_ms(2);

        // short glitch shorter than the debounce window, in IDLE and in EDIT
        btn_inc = 1'b1; repeat (8) @(negedge clk); btn_inc = 1'b0;
        wait_ms(10);
        check_all("glitch_idle");
        press(0, 0, 0, 1, "ok_edit");
        btn_inc = 1'b1; repeat (8) @(negedge clk); btn_inc = 1'b0;
        wait_ms(10);
        check_all("glitch_edit");

        // held inc: step at press, repeats at 8, 12, 16, 20 ms
        btn_inc = 1'b1;
        k = 0;
        while (tiempo_establecido[3:0] == 4'd0 && k < 160) begin
            @(negedge clk);
            k++;
        end
        chk("rep_first", tiempo_establecido, 12'h101);
        wait_ms(6);
        chk("rep_6ms", tiempo_establecido, 12'h101);
        wait_ms(4);
        chk("rep_10ms", tiempo_establecido, 12'h102);
        wait_ms(4);
        chk("rep_14ms", tiempo_establecido, 12'h103);
        wait_ms(4);
        chk("rep_18ms", tiempo_establecido, 12'h104);
        btn_inc = 1'b0;
        wait_ms(12);
        chk("rep_end", tiempo_establecido, 12'h105);
        for (int n = 0; n < 5; n++) m_apply(0, 1, 0, 0);
        check_all("rep_model");
        press(0, 0, 0, 1, "commit_105");
        chk("commit_105_val", tiempo_establecido, 12'h105);

        // tens and minutes wrap with no carry
        press(0, 0, 0, 1, "edit2");
        press(1, 0, 0, 0, "to_tens");
        press(0, 0, 1, 0, "tens_dec_0_5");
        press(0, 1, 0, 0, "tens_inc_5_0");
        chk("no_carry", tiempo_establecido[11:8], 4'd1);
        press(1, 0, 0, 0, "to_min");
        press(0, 0, 1, 0, "min_dec_1_0");
        press(0, 0, 1, 0, "min_dec_0_9");
        chk("min_9", tiempo_establecido[11:8], 4'd9);

        // zero commit is rejected
        set_value(12'h000);
        press(0, 0, 0, 1, "zero_commit");
        chk("zero_val", tiempo_establecido, 12'h000);

        // simultaneous events
        press(0, 1, 1, 0, "inc_dec_both");
        press(1, 1, 0, 0, "sel_inc");
        press(0, 1, 0, 1, "ok_inc");
        press(1, 0, 1, 1, "ok_sel_dec");

        // random single and combined presses
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    press(1, 0, 0, 0, "rnd_sel");
                2, 3, 4: press(0, 1, 0, 0, "rnd_inc");
                5, 6:    press(0, 0, 1, 0, "rnd_dec");
                7:       press(0, 0, 0, 1, "rnd_ok");
                8:       press(0, 1, 1, 0, "rnd_incdec");
                default: press(1, 0, 1, 0, "rnd_seldec");
            endcase
        end

        // reset mid-edit discards the edit
        set_value(12'h347);
        chk("pre_rst_val", tiempo_establecido, 12'h347);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_valor", tiempo_establecido, 12'h100);
        chk("midrst_digito", digito_activo, 2'd3);
        chk("midrst_editando", editando, 1'b0);
        chk("midrst_cargar", cargar, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        m_reset();
        wait_ms(5);
        check_all("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
